// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin front end for one shared pipelined FP multiplier.
// Grants at most one requester per cycle, registers its operands into the
// multiplier, and carries a {valid, id} tag alongside the multiplier pipeline
// so every product is steered back to the requester that issued it.
module fp_mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 6,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [32*N_REQ-1:0]       req_a,
    input  logic [32*N_REQ-1:0]       req_b,
    output logic [N_REQ-1:0]          gnt,
    output logic [31:0]               mul_a,
    output logic [31:0]               mul_b,
    output logic                      mul_en,
    input  logic [31:0]               mul_prod,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [31:0]               rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic [$clog2(LAT+3)-1:0]  inflight
);
    localparam int CNT_W = $clog2(LAT+3);

    logic [ID_W-1:0]           last_q, last_d;
    logic                      iss_v_q, iss_v_d;
    logic [ID_W-1:0]           iss_id_q, iss_id_d;
    logic [31:0]               mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [LAT-1:0]            tag_v_q, tag_v_d;
    logic [LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
    logic [N_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [31:0]               rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]          inflight_q, inflight_d;

    logic                      gnt_vld;
    logic [ID_W-1:0]           win;
    int                        j;

    // Round-robin search starting just after the last winner; reset blocks grants.
    always_comb begin
        gnt_vld = 1'b0;
        win     = '0;
        j       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last_q) + k) % N_REQ;
            if (!gnt_vld && req[j]) begin
                gnt_vld = 1'b1;
                win     = ID_W'(j);
            end
        end
        if (rst) gnt_vld = 1'b0;
        gnt = gnt_vld ? (N_REQ'(1) << win) : '0;
    end

    // Multiplier free-runs whenever anything is issued or in flight.
    assign mul_en = iss_v_q | (|tag_v_q);

    // Next state: pointer, issue register, tag pipeline, response, counter.
    always_comb begin
        last_d   = gnt_vld ? win : last_q;
        iss_v_d  = gnt_vld;
        iss_id_d = gnt_vld ? win : iss_id_q;
        mul_a_d  = gnt_vld ? req_a[32*int'(win) +: 32] : mul_a_q;
        mul_b_d  = gnt_vld ? req_b[32*int'(win) +: 32] : mul_b_q;

        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        if (mul_en) begin
            for (int i = LAT-1; i > 0; i--) begin
                tag_v_d[i]  = tag_v_q[i-1];
                tag_id_d[i] = tag_id_q[i-1];
            end
            tag_v_d[0]  = iss_v_q;
            tag_id_d[0] = iss_id_q;
        end

        // Last tag stage lines up with mul_prod in the same enabled cycle.
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (mul_en && tag_v_q[LAT-1]) begin
            rsp_valid_d = N_REQ'(1) << tag_id_q[LAT-1];
            rsp_data_d  = mul_prod;
            rsp_id_d    = tag_id_q[LAT-1];
        end

        case ({gnt_vld, |rsp_valid_q})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset drops all tags so stale multiplier data is never returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= ID_W'(N_REQ-1);
            iss_v_q     <= 1'b0;
            iss_id_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            inflight_q  <= '0;
        end else begin
            last_q      <= last_d;
            iss_v_q     <= iss_v_d;
            iss_id_q    <= iss_id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            inflight_q  <= inflight_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign inflight  = inflight_q;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter with a behavioural pipelined FP multiplier.
module tb_fp_mult_arbiter;
    localparam int N_REQ = 4;
    localparam int LAT   = 6;
    localparam int ID_W  = 2;

    logic                clk, rst;
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] req_a, req_b;
    logic [N_REQ-1:0]    gnt;
    logic [31:0]         mul_a, mul_b, mul_prod;
    logic                mul_en;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_data;
    logic [ID_W-1:0]     rsp_id;
    logic [3:0]          inflight;

    int n_chk  = 0;
    int n_fail = 0;

    fp_mult_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
        .mul_prod(mul_prod), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating single-precision multiply, exact for the operands used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [22:0] f;
        int          e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'h0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            f = m[46:24];
            e++;
        end else begin
            f = m[45:23];
        end
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    // Multiplier model: LAT stages, advancing only when enabled.
    logic [31:0] mp [LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            mp[0] <= fmul(mul_a, mul_b);
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign mul_prod = mp[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        req = '0;
        cyc();
        rst = 1'b0;
    endtask

    logic [31:0] exp4 [4];
    int          peak;

    initial begin
        rst = 1'b1; req = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < LAT; i++) mp[i] = 32'h0;
        // 2*3=6, 1.5*2=3, -2*4=-8, 0.5*0.5=0.25
        set_op(0, 32'h40000000, 32'h40400000); exp4[0] = 32'h40C00000;
        set_op(1, 32'h3FC00000, 32'h40000000); exp4[1] = 32'h40400000;
        set_op(2, 32'hC0000000, 32'h40800000); exp4[2] = 32'hC1000000;
        set_op(3, 32'h3F000000, 32'h3F000000); exp4[3] = 32'h3E800000;

        // Reset state; grant suppressed while rst high
        cyc();
        req = 4'b1111;
        @(negedge clk);
        chk("gnt_in_rst", 32'(gnt), 32'h0);
        cyc();
        req = '0;
        @(negedge clk);
        chk("rst_mul_a", mul_a, 32'h0);
        chk("rst_mul_b", mul_b, 32'h0);
        chk("rst_mul_en", 32'(mul_en), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        cyc();
        rst = 1'b0;

        // Single request from requester 2: 2.0*3.0
        set_op(2, 32'h40000000, 32'h40400000);
        for (int c = 0; c < 10; c++) begin
            cyc();
            req = (c == 0) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (c == 0) chk("single_gnt", 32'(gnt), 32'h4);
            if (c == 1) chk("single_mul_a", mul_a, 32'h40000000);
            if (c > 0 && c < 8) chk("single_no_rsp", 32'(rsp_valid), 32'h0);
            if (c == 7) chk("single_en_hi", 32'(mul_en), 32'h1);
            if (c == 8) begin
                chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
                chk("single_rsp_id", 32'(rsp_id), 32'h2);
                chk("single_rsp_data", rsp_data, 32'h40C00000);
            end
            if (c == 9) begin
                chk("single_en_lo", 32'(mul_en), 32'h0);
                chk("single_inflight", 32'(inflight), 32'h0);
                chk("single_rsp_off", 32'(rsp_valid), 32'h0);
            end
        end
        set_op(2, 32'hC0000000, 32'h40800000);

        // All four held from reset: grants 0,1,2,3,0; responses back-to-back
        do_reset();
        for (int c = 0; c < 14; c++) begin
            cyc();
            req = (c < 5) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 5) chk("all_gnt", 32'(gnt), 32'(1) << (c % 4));
            if (c >= 8 && c < 13) begin
                chk("all_rsp_valid", 32'(rsp_valid), 32'(1) << ((c - 8) % 4));
                chk("all_rsp_id", 32'(rsp_id), 32'((c - 8) % 4));
                chk("all_rsp_data", rsp_data, exp4[(c - 8) % 4]);
            end
            if (c == 13) chk("all_rsp_end", 32'(rsp_valid), 32'h0);
        end

        // Fairness: grant 1, then req=0011 -> 0 then 1
        for (int c = 0; c < 12; c++) begin
            cyc();
            req = (c == 0) ? 4'b0010 : (c < 3) ? 4'b0011 : 4'b0000;
            @(negedge clk);
            if (c == 0) chk("fair_gnt0", 32'(gnt), 32'h2);
            if (c == 1) chk("fair_gnt1", 32'(gnt), 32'h1);
            if (c == 2) chk("fair_gnt2", 32'(gnt), 32'h2);
            if (c == 8)  chk("fair_rsp_id0", 32'(rsp_id), 32'h1);
            if (c == 9)  chk("fair_rsp_id1", 32'(rsp_id), 32'h0);
            if (c == 9)  chk("fair_rsp_d1", rsp_data, exp4[0]);
            if (c == 10) chk("fair_rsp_id2", 32'(rsp_id), 32'h1);
            if (c == 11) chk("fair_inflight", 32'(inflight), 32'h0);
        end

        // Streaming requester 0: (2^i) * 3.0 = 3 * 2^i
        peak = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (c < 10) begin
                req = 4'b0001;
                set_op(0, {1'b0, 8'(127 + c), 23'h0}, 32'h40400000);
            end else begin
                req = 4'b0000;
            end
            @(negedge clk);
            if (int'(inflight) > peak) peak = int'(inflight);
            if (c < 10) chk("strm_gnt", 32'(gnt), 32'h1);
            if (c >= 8 && c < 18) begin
                chk("strm_rsp_valid", 32'(rsp_valid), 32'h1);
                chk("strm_rsp_data", rsp_data, {1'b0, 8'(128 + c - 8), 23'h400000});
            end
            if (c == 8) chk("strm_inflight8", 32'(inflight), 32'h8);
        end
        chk("strm_peak", 32'(peak), 32'h8);
        chk("strm_inflight_end", 32'(inflight), 32'h0);

        // Reset mid-flight: 3 ops, rst at grant+4, nothing comes back
        set_op(0, 32'h40000000, 32'h40400000);
        for (int c = 0; c < 26; c++) begin
            cyc();
            req = (c < 3) ? 4'b0001 : (c == 17) ? 4'b0010 : 4'b0000;
            rst = (c == 4);
            @(negedge clk);
            if (c < 3) chk("rstmf_gnt", 32'(gnt), 32'h1);
            if (c == 4) chk("rstmf_gnt_rst", 32'(gnt), 32'h0);
            if (c >= 5 && c < 17) chk("rstmf_no_rsp", 32'(rsp_valid), 32'h0);
            if (c == 5) begin
                chk("rstmf_inflight", 32'(inflight), 32'h0);
                chk("rstmf_en", 32'(mul_en), 32'h0);
            end
            if (c == 17) chk("rstmf_fresh_gnt", 32'(gnt), 32'h2);
            if (c == 25) begin
                chk("rstmf_rsp_valid", 32'(rsp_valid), 32'h2);
                chk("rstmf_rsp_id", 32'(rsp_id), 32'h1);
                chk("rstmf_rsp_data", rsp_data, 32'h40400000);
            end
        end

        // Idle freeze: enable low, no strobes, data held
        for (int c = 0; c < 20; c++) begin
            cyc();
            req = '0;
            @(negedge clk);
            chk("idle_en", 32'(mul_en), 32'h0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("idle_rsp_data", rsp_data, 32'h40400000);
        end
        chk("idle_inflight", 32'(inflight), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Round-robin arbiter and sequencer that shares one pipelined FP_Mult-style single-precision multiplier among `N_REQ` requesters. It accepts at most one operand pair per cycle and drives the multiplier's operand and enable inputs. A tag pipeline tracks every in-flight operation so that each product is returned to the requester that issued it. The block sits between the requesting datapath units and the multiplier instance and owns the multiplier's `start`/enable pin.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `LAT`, default 6: multiplier latency in enabled cycles, from operands-plus-enable to a valid `mul_prod`.
- `ID_W`, default `$clog2(N_REQ)`: requester id width.

Ports:
- `clk`  in  1  clock; all logic rises on the posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request; held high with operands stable until granted.
- `req_a`  in  32*N_REQ  operand A, requester i on bits `[32i+31:32i]`.
- `req_b`  in  32*N_REQ  operand B, same packing as `req_a`.
- `gnt`  out  N_REQ  one-hot combinational grant; operands are accepted in the cycle `gnt[i]` is high.
- `mul_a`, `mul_b`  out  32  registered operands to the multiplier.
- `mul_en`  out  1  multiplier start/enable; the multiplier pipeline advances only when this is high.
- `mul_prod`  in  32  multiplier product.
- `rsp_valid`  out  N_REQ  one-hot registered result strobe, one cycle wide.
- `rsp_data`  out  32  product for the strobed requester.
- `rsp_id`  out  ID_W  index of the strobed requester.
- `inflight`  out  `$clog2(LAT+3)`  count of operations granted but not yet responded.

## Operation
**Arbitration**
- A round-robin pointer `last` holds the index of the most recently granted requester. Reset value: `N_REQ-1`, so requester 0 has top priority.
- Search order is `last+1, last+2, …` modulo `N_REQ`. The first set `req` bit wins, and `gnt` is that bit.
- At most one grant per cycle. `last` updates only on a grant.
- A requester held continuously high is granted at least once every `N_REQ` cycles.

**Issue stage (registered)**
- On a grant, `mul_a`/`mul_b` are loaded with the winner's operands, `iss_v` is set to 1, and `iss_id` is set to the winner index.
- With no grant, `iss_v` is set to 0 and `mul_a`/`mul_b` hold their values.

**Enable**
- `mul_en = iss_v | (|tag_v)`, a combinational OR.
- While anything is issued or in flight, the pipeline free-runs.
- When fully idle, `mul_en` is 0 and the multiplier holds its state.

**Tag pipeline**
- Consists of `LAT` stages of `{tag_v, tag_id}`.
- Advances only in cycles where `mul_en` is 1; stage 0 loads `{iss_v, iss_id}`.
- Stage `LAT-1` aligns with `mul_prod`.

**Response stage**
- In an enabled cycle where stage `LAT-1` is valid: `rsp_data <= mul_prod`, `rsp_id <= tag_id`, and `rsp_valid <= 1<<tag_id`.
- Otherwise `rsp_valid <= 0`, and `rsp_data`/`rsp_id` hold their values.
- There is no result back-pressure: requesters must sink `rsp_valid` unconditionally.

**In-flight counter**
- `inflight` increments on a grant and decrements on a `rsp_valid` pulse.
- Both in the same cycle leaves it unchanged.
- It never exceeds `LAT+2`.

**Reset**
- Values after reset: `gnt=0`, `mul_a=0`, `mul_b=0`, `mul_en=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `inflight=0`, `last=N_REQ-1`, all `tag_v`=0, `iss_v=0`.
- A reset mid-operation discards every in-flight operation; no `rsp_valid` is produced for them.
- Operation after reset is clean: the stale multiplier contents are untagged and never returned.
- `gnt` is forced to 0 while `rst` is high.

## Timing
- Grant to `rsp_valid` latency is exactly `LAT+2` cycles (8 at default): 1 issue cycle, then `LAT` enabled cycles, then 1 response register.
- `mul_en` stays high across the whole window, so latency is never stretched.
- Throughput is one operation per cycle. Back-to-back grants yield back-to-back `rsp_valid` pulses in grant order.
- `gnt` is combinational from `req` and `last`. Requesters must not make `req` depend combinationally on `gnt`.
- `mul_en` falls in the cycle after the last in-flight tag leaves stage `LAT-1`.

## Test plan
- **Single request.** `req[2]=1` with a=2.0 (`0x40000000`), b=3.0 (`0x40400000`) → `gnt[2]` in the same cycle; 8 cycles later `rsp_valid=4'b0100`, `rsp_id=2`, `rsp_data=0x40C00000`; then `mul_en=0` and `inflight=0`.
- **All four held from reset.** `req=4'b1111` → grants in order 0,1,2,3,0,… one per cycle; `rsp_id` sequence 0,1,2,3 starting at grant+8, with no gaps.
- **Fairness after a gap.** Grant 1, then `req=4'b0011` → the next grant goes to 0 (pointer wraps past 1), then 1.
- **Streaming one requester.** `req[0]` continuously high with 10 distinct operand pairs → 10 consecutive `rsp_valid[0]` pulses, each product correct and in order; `inflight` peaks at 8.
- **Reset mid-flight.** Issue 3 operations, then assert `rst` for 1 cycle at grant+4 → no `rsp_valid` for the 3 operations in the following 12 cycles; `inflight=0`; a fresh request afterwards returns correctly after 8 cycles.
- **Idle freeze.** No requests for 20 cycles → `mul_en=0` throughout, `rsp_valid=0`, and `rsp_data` holds its last value.
